// File: rtl/wbc_rr_arbiter.sv
// Round-robin arbiter letting NM Wishbone classic masters share one slave port,
// with a slave-response watchdog that errors a stalled strobe back to its master.
module wbc_rr_arbiter #(
    parameter int NM      = 4,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int SW      = DW / 8,
    parameter int TIMEOUT = 255
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [NM-1:0]    i_mcyc,
    input  logic [NM-1:0]    i_mstb,
    input  logic [NM-1:0]    i_mwe,
    input  logic [NM*AW-1:0] i_maddr,
    input  logic [NM*DW-1:0] i_mdata,
    input  logic [NM*SW-1:0] i_msel,
    output logic [NM-1:0]    o_mack,
    output logic [NM-1:0]    o_merr,
    output logic [NM*DW-1:0] o_mdata,
    output logic             o_scyc,
    output logic             o_sstb,
    output logic             o_swe,
    output logic [AW-1:0]    o_saddr,
    output logic [DW-1:0]    o_sdata,
    output logic [SW-1:0]    o_ssel,
    input  logic             i_sack,
    input  logic             i_serr,
    input  logic [DW-1:0]    i_sdata,
    output logic [NM-1:0]    o_grant
);

    localparam int LW = $clog2(NM);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int CW = (TW > 16) ? TW : 16;
    localparam bit TO_EN = (TIMEOUT != 0);
    localparam logic [CW-1:0] TO_LIMIT  = CW'(TIMEOUT);
    localparam logic [CW-1:0] ONE_CW    = CW'(1);
    localparam logic [LW:0]   ONE_LW    = (LW+1)'(1);
    localparam logic [LW:0]   NM_LW     = (LW+1)'(NM);
    localparam logic [LW-1:0] LAST_INIT = LW'(NM - 1);
    localparam logic [NM-1:0] ONE_NM    = NM'(1);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } state_t;

    state_t        state_r;
    logic [LW-1:0] last_grant_r;
    logic [CW-1:0] wait_cnt_r;
    logic          to_err_r;
    logic [LW-1:0] pick_s;
    logic          sstb_s;
    logic          stall_s;

    // First requester strictly after 'last', wrapping; rotating the doubled
    // request vector turns the circular search into a plain lowest-bit search.
    function automatic logic [LW-1:0] rr_pick(input logic [NM-1:0] req,
                                              input logic [LW-1:0] last);
        logic [NM-1:0] rot;
        logic [LW:0]   first;
        logic [LW:0]   sum;
        logic          found;
        rot   = NM'({req, req} >> ({1'b0, last} + ONE_LW));
        first = '0;
        found = 1'b0;
        for (int i = 0; i < NM; i++) begin
            if (!found && rot[i]) begin
                first = (LW+1)'(i);
                found = 1'b1;
            end
        end
        sum = {1'b0, last} + ONE_LW + first;
        if (sum >= NM_LW) begin
            sum = sum - NM_LW;
        end
        return sum[LW-1:0];
    endfunction

    assign pick_s  = rr_pick(i_mcyc, last_grant_r);
    assign sstb_s  = (state_r == GRANTED) & i_mstb[last_grant_r] & ~to_err_r;
    assign stall_s = sstb_s & ~i_sack & ~i_serr;

    // Grant FSM, registered one-hot grant and slave-response watchdog.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_r      <= IDLE;
            o_grant      <= '0;
            last_grant_r <= LAST_INIT;
            wait_cnt_r   <= '0;
            to_err_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    wait_cnt_r <= '0;
                    to_err_r   <= 1'b0;
                    if (|i_mcyc) begin
                        state_r      <= GRANTED;
                        last_grant_r <= pick_s;
                        o_grant      <= ONE_NM << pick_s;
                    end else begin
                        state_r <= IDLE;
                        o_grant <= '0;
                    end
                end
                GRANTED: begin
                    if (!i_mcyc[last_grant_r]) begin
                        state_r    <= IDLE;
                        o_grant    <= '0;
                        wait_cnt_r <= '0;
                        to_err_r   <= 1'b0;
                    end else if (to_err_r) begin
                        to_err_r   <= 1'b0;
                        wait_cnt_r <= '0;
                    end else if (stall_s) begin
                        // A response in the limit cycle never reaches here, so it wins.
                        if (TO_EN && (wait_cnt_r == TO_LIMIT)) begin
                            to_err_r   <= 1'b1;
                            wait_cnt_r <= '0;
                        end else begin
                            wait_cnt_r <= wait_cnt_r + ONE_CW;
                        end
                    end else begin
                        wait_cnt_r <= '0;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    o_grant    <= '0;
                    wait_cnt_r <= '0;
                    to_err_r   <= 1'b0;
                end
            endcase
        end
    end

    // Combinational request/response routing between the grantee and the slave.
    always_comb begin
        o_scyc  = 1'b0;
        o_sstb  = 1'b0;
        o_swe   = 1'b0;
        o_saddr = '0;
        o_sdata = '0;
        o_ssel  = '0;
        o_mack  = '0;
        o_merr  = '0;
        o_mdata = '0;
        if (state_r == GRANTED) begin
            o_scyc  = i_mcyc[last_grant_r];
            o_sstb  = sstb_s;
            o_swe   = i_mwe[last_grant_r];
            o_saddr = i_maddr[last_grant_r*AW +: AW];
            o_sdata = i_mdata[last_grant_r*DW +: DW];
            o_ssel  = i_msel[last_grant_r*SW +: SW];
            o_mack[last_grant_r] = i_sack;
            // Timeout error is dropped if the master already abandoned the cycle.
            o_merr[last_grant_r] = i_serr | (to_err_r & i_mcyc[last_grant_r]);
            o_mdata[last_grant_r*DW +: DW] = i_sdata;
        end else begin
            o_scyc = 1'b0;
        end
    end

endmodule

// File: tb/tb_wbc_rr_arbiter.sv
// Directed bench for wbc_rr_arbiter (NM=4, TIMEOUT=4) with a grant-order scoreboard.
module tb_wbc_rr_arbiter;

    localparam int NM = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;

    logic i_clk = 1'b0;
    logic i_reset;
    logic [NM-1:0]    i_mcyc, i_mstb, i_mwe;
    logic [NM*AW-1:0] i_maddr;
    logic [NM*DW-1:0] i_mdata;
    logic [NM*SW-1:0] i_msel;
    logic [NM-1:0]    o_mack, o_merr, o_grant;
    logic [NM*DW-1:0] o_mdata;
    logic             o_scyc, o_sstb, o_swe;
    logic [AW-1:0]    o_saddr;
    logic [DW-1:0]    o_sdata;
    logic [SW-1:0]    o_ssel;
    logic             i_sack, i_serr;
    logic [DW-1:0]    i_sdata;

    int n_checks = 0;
    int n_fails  = 0;
    logic [NM-1:0] gq[$];
    logic [NM-1:0] g_exp;

    wbc_rr_arbiter #(.NM(NM), .AW(AW), .DW(DW), .SW(SW), .TIMEOUT(4)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_mcyc(i_mcyc), .i_mstb(i_mstb), .i_mwe(i_mwe),
        .i_maddr(i_maddr), .i_mdata(i_mdata), .i_msel(i_msel),
        .o_mack(o_mack), .o_merr(o_merr), .o_mdata(o_mdata),
        .o_scyc(o_scyc), .o_sstb(o_sstb), .o_swe(o_swe),
        .o_saddr(o_saddr), .o_sdata(o_sdata), .o_ssel(o_ssel),
        .i_sack(i_sack), .i_serr(i_serr), .i_sdata(i_sdata),
        .o_grant(o_grant)
    );

    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_reset = 1'b1;
        i_mcyc  = '0;
        i_mstb  = '0;
        i_mwe   = '0;
        i_mdata = '0;
        i_msel  = '0;
        i_sack  = 1'b0;
        i_serr  = 1'b0;
        i_sdata = '0;
        for (int m = 0; m < NM; m++) begin
            i_maddr[m*AW +: AW] = 32'h0000_1000 + 32'(m);
        end
        #2;
        chk("reset_grant", 128'(o_grant), 128'(4'b0000));
        chk("reset_scyc",  128'(o_scyc),  128'(1'b0));
        chk("reset_saddr", 128'(o_saddr), 128'(32'h0));
        chk("reset_mack",  128'(o_mack),  128'(4'b0000));
        chk("reset_mdata", 128'(o_mdata), 128'h0);
        step();
        step();
        i_reset = 1'b0;

        // Strobe without cycle must not win arbitration.
        i_mstb = 4'b0001;
        step();
        step();
        chk("stb_only_grant", 128'(o_grant), 128'(4'b0000));
        chk("stb_only_sstb",  128'(o_sstb),  128'(1'b0));

        // All four request together: expected grant order queued up front.
        i_mstb = 4'b1111;
        i_mcyc = 4'b1111;
        gq.push_back(4'b0001);
        gq.push_back(4'b0010);
        gq.push_back(4'b0100);
        gq.push_back(4'b1000);
        for (int k = 0; k < NM; k++) begin
            step();
            g_exp = (gq.size() > 0) ? gq.pop_front() : 4'b0000;
            chk("rr_order", 128'(o_grant), 128'(g_exp));
            chk("rr_saddr", 128'(o_saddr), 128'(32'h0000_1000 + 32'(k)));
            step();
            chk("rr_hold1", 128'(o_grant), 128'(g_exp));
            step();
            chk("rr_hold2", 128'(o_grant), 128'(g_exp));
            i_mcyc[k] = 1'b0;
            step();
            chk("rr_dead_cycle", 128'(o_grant), 128'(4'b0000));
        end
        chk("rr_queue_drained", 128'(gq.size()), 128'(0));

        // Grant held despite a competing request; one dead cycle before handover.
        i_mcyc = 4'b0100;
        step();
        chk("hold_grant2", 128'(o_grant), 128'(4'b0100));
        i_mcyc[1] = 1'b1;
        step();
        chk("hold_mid1", 128'(o_grant), 128'(4'b0100));
        step();
        chk("hold_mid2", 128'(o_grant), 128'(4'b0100));
        i_mcyc[2] = 1'b0;
        step();
        chk("hold_idle", 128'(o_grant), 128'(4'b0000));
        step();
        chk("hold_next1", 128'(o_grant), 128'(4'b0010));
        i_mcyc = 4'b0000;
        step();

        // Read then write by master 0: response routing and request pass-through.
        i_mstb = 4'b0001;
        i_maddr[0 +: AW] = 32'h0000_0010;
        i_mcyc = 4'b0001;
        step();
        chk("rd_grant", 128'(o_grant), 128'(4'b0001));
        chk("rd_saddr", 128'(o_saddr), 128'(32'h0000_0010));
        chk("rd_swe",   128'(o_swe),   128'(1'b0));
        i_sack  = 1'b1;
        i_sdata = 32'hDEAD_BEEF;
        #1;
        chk("rd_mack",  128'(o_mack),  128'(4'b0001));
        chk("rd_merr",  128'(o_merr),  128'(4'b0000));
        chk("rd_mdata", 128'(o_mdata), 128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF);
        i_sack = 1'b0;
        i_mwe[0] = 1'b1;
        i_mdata[0 +: DW] = 32'h1234_5678;
        i_msel[0 +: SW]  = 4'b1010;
        #1;
        chk("wr_swe",   128'(o_swe),   128'(1'b1));
        chk("wr_sdata", 128'(o_sdata), 128'(32'h1234_5678));
        chk("wr_ssel",  128'(o_ssel),  128'(4'b1010));
        chk("wr_mack",  128'(o_mack),  128'(4'b0000));
        i_mcyc  = 4'b0000;
        i_mwe   = 4'b0000;
        i_sdata = 32'h0;
        step();
        chk("rd_idle_grant", 128'(o_grant), 128'(4'b0000));
        chk("rd_idle_saddr", 128'(o_saddr), 128'(32'h0));

        // Silent slave: error pulse five cycles after strobe, strobe gated that cycle.
        i_mstb = 4'b0010;
        i_mcyc = 4'b0010;
        step();
        chk("to_grant", 128'(o_grant), 128'(4'b0010));
        chk("to_sstb0", 128'(o_sstb),  128'(1'b1));
        for (int c = 1; c <= 4; c++) begin
            step();
            chk("to_wait_merr", 128'(o_merr), 128'(4'b0000));
            chk("to_wait_sstb", 128'(o_sstb), 128'(1'b1));
        end
        step();
        chk("to_pulse_merr", 128'(o_merr), 128'(4'b0010));
        chk("to_pulse_sstb", 128'(o_sstb), 128'(1'b0));
        step();
        chk("to_after_merr", 128'(o_merr), 128'(4'b0000));
        chk("to_after_sstb", 128'(o_sstb), 128'(1'b1));
        i_mcyc = 4'b0000;
        step();

        // Ack in the limit cycle wins over the timeout.
        i_mstb = 4'b0100;
        i_mcyc = 4'b0100;
        step();
        chk("ack_grant", 128'(o_grant), 128'(4'b0100));
        for (int c = 1; c <= 3; c++) begin
            step();
        end
        step();
        i_sack = 1'b1;
        #1;
        chk("ack_limit_mack", 128'(o_mack), 128'(4'b0100));
        chk("ack_limit_merr", 128'(o_merr), 128'(4'b0000));
        step();
        i_sack = 1'b0;
        #1;
        chk("ack_next_merr", 128'(o_merr), 128'(4'b0000));
        step();
        chk("ack_next2_merr", 128'(o_merr), 128'(4'b0000));
        i_mcyc = 4'b0000;
        step();

        // Master abandons the cycle during the error cycle: pulse suppressed.
        i_mstb = 4'b1000;
        i_mcyc = 4'b1000;
        step();
        chk("drop_grant", 128'(o_grant), 128'(4'b1000));
        for (int c = 1; c <= 5; c++) begin
            step();
        end
        i_mcyc = 4'b0000;
        #1;
        chk("drop_merr", 128'(o_merr), 128'(4'b0000));
        chk("drop_scyc", 128'(o_scyc), 128'(1'b0));
        step();
        chk("drop_idle", 128'(o_grant), 128'(4'b0000));

        // Reset mid-grant aborts at once; fresh arbitration afterwards.
        i_mcyc = 4'b1000;
        step();
        chk("rst_pre_grant", 128'(o_grant), 128'(4'b1000));
        chk("rst_pre_scyc",  128'(o_scyc),  128'(1'b1));
        #2;
        i_reset = 1'b1;
        #1;
        chk("rst_grant", 128'(o_grant), 128'(4'b0000));
        chk("rst_scyc",  128'(o_scyc),  128'(1'b0));
        chk("rst_sstb",  128'(o_sstb),  128'(1'b0));
        i_mcyc = 4'b0010;
        i_mstb = 4'b0010;
        step();
        i_reset = 1'b0;
        #1;
        chk("rst_release_idle", 128'(o_grant), 128'(4'b0000));
        step();
        chk("rst_regrant", 128'(o_grant), 128'(4'b0010));
        i_mcyc = 4'b0000;
        step();
        chk("final_idle", 128'(o_grant), 128'(4'b0000));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
